// File: rtl/fig_06_block_152_ctrl.sv
// Sequencer for the Figure 6 ALU adder/subtractor (block 152).
// Runs one arithmetic request as one or two passes through block 152,
// returns the result with a write strobe, and owns the {cy,ov,z,s} flags.
// Block 152 has no carry-in, so ADC/SBC with an active carry take a
// second pass that adds or subtracts one.
module fig_06_block_152_ctrl #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_load,
  input  logic [3:0]       flag_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             err,
  output logic             cy,
  output logic             ov,
  output logic             z,
  output logic             s,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sel,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_cy,
  input  logic             add_ov
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t     state, next_state;
  logic [2:0] op_q;
  logic       c1_q;    // raw block 152 cy from pass 1 (carry or borrow)
  logic       ov1_q;
  logic [3:0] flags;   // {cy,ov,z,s}

  logic       req_reserved;
  logic       need_pass2;
  logic       finish;
  logic       fin_cy;
  logic       fin_ov;

  assign req_reserved = (op > OP_CMP);
  // The carry flag cannot change between accept and PASS1, so this is the
  // cy value the operation was accepted with (including a coincident load).
  assign need_pass2   = ((op_q == OP_ADC) &&  flags[3]) ||
                        ((op_q == OP_SBC) && !flags[3]);
  assign finish       = ((state == PASS1) && !need_pass2) || (state == PASS2);

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign err    = done && (op_q > OP_CMP);
  assign wr_en  = done && (op_q != OP_CMP) && (op_q <= OP_CMP);
  assign {cy, ov, z, s} = flags;

  // Final flags from the pass that completes the operation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    fin_cy = add_cy;
    fin_ov = add_ov;
    if (state == PASS2) begin
      fin_ov = ov1_q ^ add_ov;
      // ADC pass 2 is x - FFFF: no borrow only when x was FFFF, i.e. the +1 carried out.
      // SBC pass 2 is x - 1: a borrow in either pass means an overall borrow.
      fin_cy = (op_q == OP_ADC) ? (c1_q | !add_cy) : !(c1_q | add_cy);
    end else if ((op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP)) begin
      fin_cy = !add_cy;  // flag cy means "no borrow"
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (req) next_state = req_reserved ? DONE : PASS1;
      PASS1: next_state = need_pass2 ? PASS2 : DONE;
      PASS2: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand latch, block 152 drive, pass-1 capture, result and flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_ADD;
      c1_q    <= 1'b0;
      ov1_q   <= 1'b0;
      flags   <= FLAG_RST;
      result  <= '0;
      add_x   <= '0;
      add_y   <= '0;
      add_sel <= 1'b0;
    end else begin
      if ((state == IDLE) && flag_load) flags <= flag_in;
      if ((state == IDLE) && req) begin
        op_q <= op;
        if (req_reserved) begin
          result <= '0;
        end else begin
          add_x   <= a;
          add_y   <= b;
          add_sel <= (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
        end
      end
      if ((state == PASS1) && need_pass2) begin
        c1_q    <= add_cy;
        ov1_q   <= add_ov;
        add_x   <= add_z;
        add_y   <= (op_q == OP_ADC) ? {WIDTH{1'b1}} : WIDTH'(1);
        add_sel <= 1'b1;
      end
      if (finish) begin
        result <= add_z;
        flags  <= {fin_cy, fin_ov, (add_z == '0), add_z[WIDTH-1]};
      end
    end
  end

endmodule
